// File: rtl/fetch_pkg.sv
// Shared fetch-pack definitions used by the fetch queue and its storage.
// Holds the front-end widths and the packed layouts of the branch-predict
// pack and the full fetch pack as stored in the queue.
package fetch_pkg;

    localparam int FETCH_WIDTH = 2;
    localparam int INST_W      = 32;
    localparam int XLEN        = 64;
    localparam int BP_PACK_W   = 71;

    // Bit order matches the flat io_*_bp_pack ports, MSB first.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] target;
        logic [3:0]      branch_type;
        logic            select;
        logic            taken;
    } bp_pack_t;

    typedef struct packed {
        logic [FETCH_WIDTH-1:0]        valids;
        logic [XLEN-1:0]               pc;
        logic [FETCH_WIDTH*INST_W-1:0] insts;
        bp_pack_t                      bp_pack;
    } fetch_pack_t;

    localparam int FETCH_PACK_W = $bits(fetch_pack_t);

endpackage

// File: rtl/fetch_queue_mem.sv
// Register-array storage for the fetch queue.
// Ports:
//   clock  - core clock
//   we     - write enable, writes wdata into entry waddr at the rising edge
//   waddr  - write index
//   wdata  - fetch pack to store
//   raddr  - read index
//   rdata  - asynchronous read of entry raddr
// Contents are not reset; the owner tracks which entries are live.
module fetch_queue_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  fetch_pack_t       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output fetch_pack_t       rdata
);

    fetch_pack_t mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: circular FIFO of fetch packs between fetch-result and decode.
// Ports:
//   clock, reset          - core clock, synchronous active-high reset
//   io_i_flush            - pipeline redirect; empties the queue at the next edge
//   io_i_pack_valid, io_i_valids, io_i_pc, io_i_insts, io_i_bp_pack
//                         - incoming fetch pack
//   io_o_stall            - queue full, fetch must hold
//   io_o_pack_valid, io_o_valids, io_o_pc, io_o_insts, io_o_bp_pack
//                         - oldest pack toward decode
//   io_i_ready            - decode takes the head this cycle
// Optional build macro FETCH_QUEUE_PERF_EN adds io_o_perf_full_cycles and
// io_o_perf_enq_count, saturating counters cleared only by reset.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          io_i_flush,
    input  logic                          io_i_pack_valid,
    input  logic [FETCH_WIDTH-1:0]        io_i_valids,
    input  logic [XLEN-1:0]               io_i_pc,
    input  logic [FETCH_WIDTH*INST_W-1:0] io_i_insts,
    input  logic [BP_PACK_W-1:0]          io_i_bp_pack,
    output logic                          io_o_stall,
    output logic                          io_o_pack_valid,
    output logic [FETCH_WIDTH-1:0]        io_o_valids,
    output logic [XLEN-1:0]               io_o_pc,
    output logic [FETCH_WIDTH*INST_W-1:0] io_o_insts,
    output logic [BP_PACK_W-1:0]          io_o_bp_pack,
    input  logic                          io_i_ready
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]                   io_o_perf_full_cycles,
    output logic [31:0]                   io_o_perf_enq_count
`endif
);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0] head_q, head_d;
    logic [PTR_W:0] tail_q, tail_d;
    logic           empty, full;
    logic           enq_fire, deq_fire;
    fetch_pack_t    wr_pack, rd_pack;

    assign empty = (head_q == tail_q);
    assign full  = (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]) &&
                   (head_q[PTR_W] != tail_q[PTR_W]);

    assign io_o_stall      = full;
    assign io_o_pack_valid = ~empty & ~io_i_flush;

    // Full refuses enqueue even when a dequeue frees a slot this cycle.
    assign enq_fire = io_i_pack_valid & ~full & ~io_i_flush;
    assign deq_fire = io_o_pack_valid & io_i_ready;

    assign wr_pack.valids  = io_i_valids;
    assign wr_pack.pc      = io_i_pc;
    assign wr_pack.insts   = io_i_insts;
    assign wr_pack.bp_pack = bp_pack_t'(io_i_bp_pack);

    fetch_queue_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clock (clock),
        .we    (enq_fire),
        .waddr (tail_q[PTR_W-1:0]),
        .wdata (wr_pack),
        .raddr (head_q[PTR_W-1:0]),
        .rdata (rd_pack)
    );

    assign io_o_valids  = rd_pack.valids;
    assign io_o_pc      = rd_pack.pc;
    assign io_o_insts   = rd_pack.insts;
    assign io_o_bp_pack = rd_pack.bp_pack;

    // Pointer increments wrap naturally modulo 2*DEPTH.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (io_i_flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (deq_fire) begin
                head_d = head_q + (PTR_W+1)'(1);
            end
            if (enq_fire) begin
                tail_d = tail_q + (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_full_q, perf_full_d;
    logic [31:0] perf_enq_q,  perf_enq_d;

    // Saturating counters; flush intentionally leaves them alone.
    always_comb begin
        perf_full_d = perf_full_q;
        perf_enq_d  = perf_enq_q;
        if (full && (perf_full_q != 32'hFFFF_FFFF)) begin
            perf_full_d = perf_full_q + 32'd1;
        end
        if (enq_fire && (perf_enq_q != 32'hFFFF_FFFF)) begin
            perf_enq_d = perf_enq_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_full_q <= '0;
            perf_enq_q  <= '0;
        end else begin
            perf_full_q <= perf_full_d;
            perf_enq_q  <= perf_enq_d;
        end
    end

    assign io_o_perf_full_cycles = perf_full_q;
    assign io_o_perf_enq_count   = perf_enq_q;
`endif

endmodule
